// File: rtl/package_settings.sv
// Shared types, widths and power-up defaults for the trapezoidal filter sequencer.
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int CFG_K_W          = 8;
    localparam int CFG_L_W          = 8;
    localparam int CFG_M_W          = 16;

    localparam logic [CFG_K_W-1:0]                 DEF_K   = 8'd8;
    localparam logic [CFG_L_W-1:0]                 DEF_L   = 8'd4;
    localparam logic [CFG_M_W-1:0]                 DEF_M   = 16'd100;
    localparam logic signed [SIZE_FILTER_DATA-1:0] DEF_THR = 16'sd100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_ARMED,
        ST_ABOVE,
        ST_HOLDOFF
    } state_t;

    // k must be non-zero, the gap may not exceed the rise, and k+l must fit the delay line
    function automatic logic cfg_is_legal(input logic [CFG_K_W-1:0] k,
                                          input logic [CFG_L_W-1:0] l);
        logic [CFG_K_W:0] sum;
        sum = {1'b0, k} + {1'b0, l};
        return (k != '0) && ({1'b0, l} <= {1'b0, k}) && !sum[CFG_K_W];
    endfunction

endpackage

// File: rtl/filter_event_buf.sv
// One-entry event holding register with drop accounting for the filter sequencer.
module filter_event_buf
    import package_settings::*;
#(
    parameter int TS_W = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic signed [SIZE_FILTER_DATA-1:0] push_peak,
    input  logic [TS_W-1:0]                    push_time,
    input  logic                               ev_ready,
    output logic                               ev_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_peak,
    output logic [TS_W-1:0]                    ev_time,
    output logic [7:0]                         lost_count
);

    logic                               valid_reg;
    logic signed [SIZE_FILTER_DATA-1:0] peak_reg;
    logic [TS_W-1:0]                    time_reg;
    logic [7:0]                         lost_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            peak_reg  <= '0;
            time_reg  <= '0;
            lost_reg  <= '0;
        end else if (push) begin
            // A pop in the same cycle frees the slot, so the new event takes it
            if (!valid_reg || ev_ready) begin
                valid_reg <= 1'b1;
                peak_reg  <= push_peak;
                time_reg  <= push_time;
            end else if (lost_reg != 8'hFF) begin
                lost_reg <= lost_reg + 8'd1;
            end
        end else if (ev_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign ev_valid   = valid_reg;
    assign ev_peak    = peak_reg;
    assign ev_time    = time_reg;
    assign lost_count = lost_reg;

endmodule

// File: rtl/filter_seq_ctrl.sv
// Reconfiguration sequencer and threshold-crossing event front-end for the trapezoidal filter.
module filter_seq_ctrl
    import package_settings::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int PIPE_LAT     = 6,
    parameter int HOLDOFF      = 16,
    parameter int TS_W         = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [CFG_K_W-1:0]                 cfg_k,
    input  logic [CFG_L_W-1:0]                 cfg_l,
    input  logic [CFG_M_W-1:0]                 cfg_m,
    input  logic signed [SIZE_FILTER_DATA-1:0] cfg_thr,
    output logic                               cfg_err,
    output logic                               flt_reset,
    output logic [CFG_K_W-1:0]                 flt_k,
    output logic [CFG_L_W-1:0]                 flt_l,
    output logic [CFG_M_W-1:0]                 flt_m,
    input  logic signed [SIZE_FILTER_DATA-1:0] flt_data,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_peak,
    output logic [TS_W-1:0]                    ev_time,
    output logic                               busy,
    output logic [7:0]                         lost_count
);

    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF - 1);
    localparam logic [15:0] PIPE_LAT_C = 16'(PIPE_LAT);

    state_t                             state_reg, state_next;
    logic [15:0]                        cnt_reg, cnt_next;
    logic [TS_W-1:0]                    ts_reg;
    logic [CFG_K_W-1:0]                 k_reg;
    logic [CFG_L_W-1:0]                 l_reg;
    logic [CFG_M_W-1:0]                 m_reg;
    logic signed [SIZE_FILTER_DATA-1:0] thr_reg;
    logic signed [SIZE_FILTER_DATA-1:0] peak_reg, peak_next;
    logic [TS_W-1:0]                    time_reg, time_next;
    logic                               err_reg;
    logic                               cfg_fire;
    logic                               cfg_load;
    logic                               ev_push;

    assign cfg_ready = (state_reg != ST_FLUSH) && (state_reg != ST_SETTLE);
    assign busy      = !cfg_ready;
    assign flt_reset = (state_reg != ST_IDLE) && (state_reg != ST_FLUSH);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_load  = cfg_fire && cfg_is_legal(cfg_k, cfg_l);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ts_reg    <= '0;
            k_reg     <= DEF_K;
            l_reg     <= DEF_L;
            m_reg     <= DEF_M;
            thr_reg   <= DEF_THR;
            peak_reg  <= '0;
            time_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ts_reg    <= ts_reg + 1'b1;
            peak_reg  <= peak_next;
            time_reg  <= time_next;
            err_reg   <= cfg_fire && !cfg_load;
            if (cfg_load) begin
                k_reg   <= cfg_k;
                l_reg   <= cfg_l;
                m_reg   <= cfg_m;
                thr_reg <= cfg_thr;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        peak_next  = peak_reg;
        time_next  = time_reg;
        ev_push    = 1'b0;
        case (state_reg)
            ST_FLUSH: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SETTLE;
                    cnt_next   = 16'(k_reg) + 16'(l_reg) + PIPE_LAT_C - 16'd1;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) state_next = ST_ARMED;
                else               cnt_next   = cnt_reg - 16'd1;
            end
            ST_ARMED: begin
                if (flt_data > thr_reg) begin
                    peak_next  = flt_data;
                    time_next  = ts_reg;
                    state_next = ST_ABOVE;
                end
            end
            ST_ABOVE: begin
                if (flt_data <= thr_reg) begin
                    ev_push    = 1'b1;
                    state_next = ST_HOLDOFF;
                    cnt_next   = HOLD_LOAD;
                end else if (flt_data > peak_reg) begin
                    peak_next = flt_data;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_reg == '0) state_next = ST_ARMED;
                else               cnt_next   = cnt_reg - 16'd1;
            end
            default: ;
        endcase
        // A legal reconfiguration overrides everything, including a pulse in flight
        if (cfg_load) begin
            state_next = ST_FLUSH;
            cnt_next   = FLUSH_LOAD;
            ev_push    = 1'b0;
        end
    end

    filter_event_buf #(
        .TS_W(TS_W)
    ) u_event_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_push),
        .push_peak (peak_reg),
        .push_time (time_reg),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_peak   (ev_peak),
        .ev_time   (ev_time),
        .lost_count(lost_count)
    );

    assign cfg_err = err_reg;
    assign flt_k   = k_reg;
    assign flt_l   = l_reg;
    assign flt_m   = m_reg;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Scoreboard bench for filter_seq_ctrl: expected events queued as pulses are driven, compared every cycle.
module tb_filter_seq_ctrl;
    import package_settings::*;

    localparam int FC = 4;
    localparam int PL = 6;
    localparam int HO = 16;
    localparam int TW = 32;
    localparam int DW = SIZE_FILTER_DATA;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [7:0]           cfg_k = '0;
    logic [7:0]           cfg_l = '0;
    logic [15:0]          cfg_m = '0;
    logic signed [DW-1:0] cfg_thr = '0;
    logic                 cfg_err;
    logic                 flt_reset;
    logic [7:0]           flt_k;
    logic [7:0]           flt_l;
    logic [15:0]          flt_m;
    logic signed [DW-1:0] flt_data = '0;
    logic                 ev_valid;
    logic                 ev_ready = 1'b0;
    logic signed [DW-1:0] ev_peak;
    logic [TW-1:0]        ev_time;
    logic                 busy;
    logic [7:0]           lost_count;

    filter_seq_ctrl #(
        .FLUSH_CYCLES(FC),
        .PIPE_LAT    (PL),
        .HOLDOFF     (HO),
        .TS_W        (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_k     (cfg_k),
        .cfg_l     (cfg_l),
        .cfg_m     (cfg_m),
        .cfg_thr   (cfg_thr),
        .cfg_err   (cfg_err),
        .flt_reset (flt_reset),
        .flt_k     (flt_k),
        .flt_l     (flt_l),
        .flt_m     (flt_m),
        .flt_data  (flt_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_peak   (ev_peak),
        .ev_time   (ev_time),
        .busy      (busy),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] peak;
        logic [TW-1:0]        t;
    } ev_t;

    ev_t exp_q[$];
    ev_t fire_ev;
    bit  ev_fire = 0;
    int  exp_lost = 0;
    int  tsm = 0;
    int  cur_thr = 0;
    int  seq[$];
    int  checks = 0;
    int  errors = 0;

    // One clock: update the reference event buffer at the edge, then compare outputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            tsm++;
            if (ev_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ev_fire) begin
                if (exp_q.size() == 0) exp_q.push_back(fire_ev);
                else if (exp_lost < 255) exp_lost++;
            end
        end
        ev_fire = 0;
        #1;
        checks++;
        if (ev_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL ev_valid t=%0d got %0b want %0b", tsm, ev_valid, exp_q.size() != 0);
        end
        checks++;
        if (lost_count !== 8'(exp_lost)) begin
            errors++;
            $display("FAIL lost_count t=%0d got %0d want %0d", tsm, lost_count, exp_lost);
        end
        if (exp_q.size() > 0) begin
            checks++;
            if (ev_peak !== exp_q[0].peak || ev_time !== exp_q[0].t) begin
                errors++;
                $display("FAIL ev_data t=%0d got peak %0d time %0d want peak %0d time %0d",
                         tsm, ev_peak, ev_time, exp_q[0].peak, exp_q[0].t);
            end
        end
    endtask

    task automatic do_config(input int k, input int l, input int m, input int thr);
        bit          legal;
        logic [7:0]  ok, ol;
        logic [15:0] om;
        logic        ob;
        int          n;
        legal = (k != 0) && (l <= k) && (k + l <= 255);
        ok = flt_k; ol = flt_l; om = flt_m; ob = busy;
        cfg_k = 8'(k); cfg_l = 8'(l); cfg_m = 16'(m); cfg_thr = DW'(thr);
        cfg_valid = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready got %0b want 1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        flt_data = '0;
        if (legal) begin
            cur_thr = thr;
            checks++;
            if (flt_k !== 8'(k) || flt_l !== 8'(l) || flt_m !== 16'(m) || flt_reset !== 1'b0
                || busy !== 1'b1 || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_load got k %0d l %0d m %0d rst %0b busy %0b err %0b want %0d %0d %0d 0 1 0",
                         flt_k, flt_l, flt_m, flt_reset, busy, cfg_err, k, l, m);
            end
            n = 0;
            while (flt_reset === 1'b0 && n < 100) begin
                n++;
                tick();
            end
            checks++;
            if (n != FC) begin
                errors++;
                $display("FAIL flush_len got %0d want %0d", n, FC);
            end
            while (busy === 1'b1 && n < 1000) begin
                n++;
                tick();
            end
            checks++;
            if (n != FC + k + l + PL || cfg_ready !== 1'b1 || flt_reset !== 1'b1) begin
                errors++;
                $display("FAIL busy_len got %0d ready %0b rst %0b want %0d 1 1",
                         n, cfg_ready, flt_reset, FC + k + l + PL);
            end
        end else begin
            checks++;
            if (cfg_err !== 1'b1 || flt_k !== ok || flt_l !== ol || flt_m !== om || busy !== ob) begin
                errors++;
                $display("FAIL cfg_reject got err %0b k %0d l %0d m %0d busy %0b want 1 %0d %0d %0d %0b",
                         cfg_err, flt_k, flt_l, flt_m, busy, ok, ol, om, ob);
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse got %0b want 0", cfg_err);
            end
        end
    endtask

    // Drives seq[] while ARMED; the model predicts the event it should produce.
    task automatic run_seq(input bit pop_last);
        bit            above;
        int            peak;
        logic [TW-1:0] t;
        above = 0;
        peak = 0;
        t = '0;
        for (int i = 0; i < seq.size(); i++) begin
            flt_data = DW'(seq[i]);
            ev_ready = pop_last && (i == seq.size() - 1);
            if (!above) begin
                if (seq[i] > cur_thr) begin
                    above = 1;
                    peak = seq[i];
                    t = TW'(tsm);
                end
            end else if (seq[i] <= cur_thr) begin
                ev_fire = 1;
                fire_ev.peak = DW'(peak);
                fire_ev.t = t;
                above = 0;
            end else if (seq[i] > peak) begin
                peak = seq[i];
            end
            tick();
        end
        flt_data = '0;
        ev_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #20;
        checks++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || flt_reset !== 1'b0 || busy !== 1'b0
            || flt_k !== DEF_K || flt_l !== DEF_L || flt_m !== DEF_M || ev_valid !== 1'b0
            || ev_peak !== '0 || ev_time !== '0 || lost_count !== '0) begin
            errors++;
            $display("FAIL reset_vals got ready %0b err %0b rst %0b busy %0b k %0d l %0d m %0d v %0b p %0d t %0d lost %0d",
                     cfg_ready, cfg_err, flt_reset, busy, flt_k, flt_l, flt_m, ev_valid, ev_peak, ev_time, lost_count);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        tsm = 0;
        idle(9);
        checks++;
        if (flt_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got rst %0b busy %0b want 0 0", flt_reset, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_config();
        do_config(8, 4, 100, 50);
        $display("test_config k=8 l=4 accepted, armed at ts %0d", tsm);
    endtask

    task automatic test_pulse();
        int t60;
        t60 = tsm + 1;
        seq = '{0, 60, 120, 120, 80, 40};
        run_seq(0);
        checks++;
        if (ev_valid !== 1'b1 || ev_peak !== 16'sd120 || ev_time !== TW'(t60)) begin
            errors++;
            $display("FAIL pulse_event got v %0b peak %0d time %0d want 1 120 %0d", ev_valid, ev_peak, ev_time, t60);
        end
        drain();
        idle(HO + 2);
        $display("test_pulse peak=120 time=%0d", t60);
    endtask

    task automatic test_lost();
        for (int p = 0; p < 3; p++) begin
            seq = '{70, 90 + p, 30};
            run_seq(0);
            idle(HO + 4);
        end
        checks++;
        if (lost_count !== 8'd2 || ev_peak !== 16'sd90) begin
            errors++;
            $display("FAIL lost_hold got lost %0d peak %0d want 2 90", lost_count, ev_peak);
        end
        seq = '{70, 93, 30};
        run_seq(1);
        checks++;
        if (lost_count !== 8'd2 || ev_valid !== 1'b1 || ev_peak !== 16'sd93) begin
            errors++;
            $display("FAIL pop_and_load got lost %0d v %0b peak %0d want 2 1 93", lost_count, ev_valid, ev_peak);
        end
        drain();
        idle(HO + 2);
        $display("test_lost lost_count=%0d", lost_count);
    endtask

    task automatic test_illegal();
        do_config(4, 6, 7, 10);
        do_config(0, 3, 7, 10);
        do_config(200, 100, 7, 10);
        seq = '{55, 20};
        run_seq(0);
        checks++;
        if (ev_peak !== 16'sd55) begin
            errors++;
            $display("FAIL still_armed got peak %0d want 55", ev_peak);
        end
        drain();
        idle(HO + 2);
        $display("test_illegal three configs rejected");
    endtask

    task automatic test_abort();
        seq = '{200, 200, 200};
        run_seq(0);
        flt_data = 16'sd200;
        do_config(6, 2, 300, 80);
        seq = '{100, 150, 50};
        run_seq(0);
        checks++;
        if (ev_peak !== 16'sd150) begin
            errors++;
            $display("FAIL after_abort got peak %0d want 150", ev_peak);
        end
        drain();
        idle(HO + 2);
        $display("test_abort no event from aborted pulse");
    endtask

    task automatic test_reset_mid();
        int texp;
        seq = '{120, 10};
        run_seq(0);
        idle(HO + 4);
        flt_data = 16'sd200;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (ev_valid !== 1'b0 || ev_peak !== '0 || ev_time !== '0 || lost_count !== '0
            || flt_reset !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0
            || flt_k !== DEF_K || flt_l !== DEF_L || flt_m !== DEF_M) begin
            errors++;
            $display("FAIL async_reset got v %0b p %0d t %0d lost %0d rst %0b busy %0b k %0d l %0d m %0d",
                     ev_valid, ev_peak, ev_time, lost_count, flt_reset, busy, flt_k, flt_l, flt_m);
        end
        exp_q.delete();
        exp_lost = 0;
        tsm = 0;
        flt_data = '0;
        tick();
        tick();
        reset = 1'b1;
        do_config(8, 4, 100, 50);
        texp = tsm;
        seq = '{60, 30};
        run_seq(0);
        checks++;
        if (ev_time !== TW'(texp)) begin
            errors++;
            $display("FAIL ts_restart got %0d want %0d", ev_time, texp);
        end
        drain();
        $display("test_reset_mid ts restarted, event time %0d", texp);
    endtask

    initial begin
        test_reset();
        test_config();
        test_pulse();
        test_lost();
        test_illegal();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
